// File: rtl/cpu_controller_fsm.sv
// ---------------------------------------------------------------------------
// cpu_controller_fsm
//
// Moore controller that walks the register-file/ALU datapath through one
// instruction at a time. The decoder's opcode/op fields are captured when an
// instruction is accepted in WAIT. Every later decision uses that captured
// copy, so the decoder is free to change underneath a running instruction.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous, active-low reset (forces WAIT immediately)
//   s          start: accept the current instruction (only looked at in WAIT)
//   opcode     instruction class from the decoder (110 = MOV, 101 = ALU)
//   op         sub-op from the decoder
//   w          1 while idle in WAIT and ready for s
//   nsel       one-hot register select: 100 = Rn, 010 = Rd, 001 = Rm, 000 = none
//   vsel       writeback source: 00 = datapath C, 10 = sign-extended im8
//   loada      load A register
//   loadb      load B register
//   loadc      load C register
//   loads      load status flags
//   asel       1 = force ALU A input to zero
//   bsel       1 = ALU B from im5 (this controller never uses it)
//   write      register-file write enable
//   state_dbg  current state code
// ---------------------------------------------------------------------------
module cpu_controller_fsm (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       write,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_GETA      = 3'd2,
        S_GETB      = 3'd3,
        S_COMPUTE   = 3'd4,
        S_WRITE_REG = 3'd5,
        S_WRITE_IMM = 3'd6,
        S_UNUSED    = 3'd7
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [2:0] opcode_q;
    logic [1:0] op_q;
    logic [4:0] instr_q;
    logic       is_cmp;
    logic       is_a_zero;

    assign instr_q = {opcode_q, op_q};

    // CMP only updates flags; MOV reg and MVN pass Rm through with A forced
    // to zero, so both route around GETA and need asel in COMPUTE.
    assign is_cmp    = (instr_q == 5'b101_01);
    assign is_a_zero = (instr_q == 5'b110_00) || (instr_q == 5'b101_11);

    // State register. Reset drops straight to WAIT so any in-flight write or
    // load strobe disappears in the same instant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_WAIT;
        end else begin
            state <= next_state;
        end
    end

    // Capture the instruction fields at the accepting edge only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opcode_q <= 3'b000;
            op_q     <= 2'b00;
        end else if (state == S_WAIT && s) begin
            opcode_q <= opcode;
            op_q     <= op;
        end
    end

    // Next-state logic. Unrecognised instructions and the unused code both
    // fall back to WAIT without touching the datapath.
    always_comb begin
        next_state = S_WAIT;
        case (state)
            S_WAIT:   next_state = s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                case (instr_q)
                    5'b110_10:                       next_state = S_WRITE_IMM;
                    5'b110_00:                       next_state = S_GETB;
                    5'b101_00, 5'b101_01, 5'b101_10: next_state = S_GETA;
                    5'b101_11:                       next_state = S_GETB;
                    default:                         next_state = S_WAIT;
                endcase
            end
            S_GETA:      next_state = S_GETB;
            S_GETB:      next_state = S_COMPUTE;
            S_COMPUTE:   next_state = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: next_state = S_WAIT;
            S_WRITE_IMM: next_state = S_WAIT;
            default:     next_state = S_WAIT;
        endcase
    end

    // Moore outputs: a function of the state and the captured instruction.
    always_comb begin
        w     = 1'b0;
        nsel  = 3'b000;
        vsel  = 2'b00;
        loada = 1'b0;
        loadb = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        asel  = 1'b0;
        bsel  = 1'b0;
        write = 1'b0;
        case (state)
            S_WAIT: w = 1'b1;
            S_GETA: begin
                nsel  = 3'b100;
                loada = 1'b1;
            end
            S_GETB: begin
                nsel  = 3'b001;
                loadb = 1'b1;
            end
            S_COMPUTE: begin
                if (is_cmp) begin
                    loads = 1'b1;
                end else begin
                    loadc = 1'b1;
                    asel  = is_a_zero;
                end
            end
            S_WRITE_REG: begin
                nsel  = 3'b010;
                vsel  = 2'b00;
                write = 1'b1;
            end
            S_WRITE_IMM: begin
                nsel  = 3'b100;
                vsel  = 2'b10;
                write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state_dbg = state;

endmodule
